// File: rtl/fpu_arbiter.sv
// fpu_arbiter
//   Shares one vector FPU between NUM_REQ requesters. Requests are granted
//   round-robin starting at a rotating pointer. A requester with MAX_OUT
//   requests in flight is skipped. Responses are routed back by the returned
//   tag. A flush input aborts all in-flight work: every outstanding count is
//   cleared, and the FPU sees a registered flush strobe.
//
// Ports
//   clock, reset                  clock; asynchronous active-high reset
//   req_valid/req_ready/req_bits  per-requester request channel
//   resp_valid/resp_ready         per-requester response handshake
//   resp_bits                     response payload, broadcast to all requesters
//   fpu_req_*                     request channel to the FPU (tag = requester)
//   fpu_resp_*                    response channel from the FPU
//   flush / fpu_flush             flush request in / flush strobe to the FPU
//   busy                          some requester has outstanding work
module fpu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 1560,
  parameter int RESP_W  = 517,
  parameter int MAX_OUT = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*REQ_W-1:0] req_bits,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [RESP_W-1:0]        resp_bits,
  output logic                     fpu_req_valid,
  input  logic                     fpu_req_ready,
  output logic [REQ_W-1:0]         fpu_req_bits,
  output logic [ID_W-1:0]          fpu_req_tag,
  input  logic                     fpu_resp_valid,
  output logic                     fpu_resp_ready,
  input  logic [RESP_W-1:0]        fpu_resp_bits,
  input  logic [ID_W-1:0]          fpu_resp_tag,
  input  logic                     flush,
  output logic                     fpu_flush,
  output logic                     busy
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e                          state_q, state_d;
  logic                            run;
  logic [ID_W-1:0]                 ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                            lock_vld_q, lock_vld_d;
  logic [ID_W-1:0]                 lock_idx_q, lock_idx_d;

  logic                            open;
  logic [NUM_REQ-1:0]              eligible;
  logic                            grant_vld;
  logic [ID_W-1:0]                 grant_idx;
  logic [ID_W-1:0]                 scan_idx;
  logic                            tag_ok;
  logic [NUM_REQ-1:0]              delivered;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush)  state_d = ST_FLUSH;
      ST_FLUSH: if (!flush) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    run       = (state_q == ST_RUN);
    fpu_flush = (state_q == ST_FLUSH);
  end

  // Both channels close during FLUSH, while flush is raised, and during
  // reset, so that no handshake can complete while reset is asserted.
  assign open = run && !flush && !reset;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = open && req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
  end

  // A grant stalled by fpu_req_ready stays on the same requester. Otherwise
  // a response could unblock a requester nearer to the pointer and steal
  // the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (lock_vld_q && eligible[lock_idx_q]) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      // Scan from the farthest offset down, so the nearest eligible index wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
        if (eligible[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    fpu_req_valid = grant_vld;
    fpu_req_tag   = grant_idx;
    fpu_req_bits  = '0;
    req_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        fpu_req_bits = req_bits[i*REQ_W +: REQ_W];
        req_ready[i] = grant_vld && fpu_req_ready;
      end
    end
  end

  // The tag range check only matters when NUM_REQ is not a power of two.
  assign tag_ok    = (int'(fpu_resp_tag) < NUM_REQ);
  assign resp_bits = fpu_resp_bits;

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      resp_valid[i] = fpu_resp_valid && open && (fpu_resp_tag == ID_W'(i));
    fpu_resp_ready = open && tag_ok && resp_ready[fpu_resp_tag];
    delivered      = resp_valid & resp_ready;
  end

  // Outstanding counts. A response to an idle requester still goes through,
  // and its count saturates at zero. A flush clears every count.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_ready[i] && !delivered[i])
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!req_ready[i] && delivered[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
    if (flush) cnt_d = '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld && fpu_req_ready)
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    lock_vld_d = grant_vld && !fpu_req_ready;
    lock_idx_d = grant_idx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (cnt_q[i] != '0) busy = 1'b1;
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one vector FPU; legal 2..8.
REQ-002 Parameter REQ_W, default 1560, opaque request payload width (3 operands + rounding/op/format/mask fields).
REQ-003 Parameter RESP_W, default 517, opaque response payload width (result + 5-bit status).
REQ-004 Parameter MAX_OUT, default 4, max in-flight requests per requester; ID_W = clog2(NUM_REQ), CNT_W = clog2(MAX_OUT+1).
REQ-005 clock  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 req_ready  output  NUM_REQ  per-requester request accepted.
REQ-009 req_bits  input  NUM_REQ*REQ_W  payloads; requester i occupies bits [i*REQ_W +: REQ_W].
REQ-010 resp_valid  output  NUM_REQ  response valid, one-hot or zero.
REQ-011 resp_ready  input  NUM_REQ  per-requester response ready.
REQ-012 resp_bits  output  RESP_W  response payload, broadcast to all requesters.
REQ-013 fpu_req_valid / fpu_req_ready  output / input  1 / 1  FPU request handshake.
REQ-014 fpu_req_bits / fpu_req_tag  output  REQ_W / ID_W  selected payload; tag = granted requester index.
REQ-015 fpu_resp_valid / fpu_resp_ready  input / output  1 / 1  FPU response handshake.
REQ-016 fpu_resp_bits / fpu_resp_tag  input  RESP_W / ID_W  FPU result and returned tag.
REQ-017 flush  input  1  request to abort all in-flight FPU work.
REQ-018 fpu_flush  output  1  flush strobe to FPU.
REQ-019 busy  output  1  any requester has outstanding work.

Function
REQ-020 Eligible(i) = req_valid[i] and cnt[i] < MAX_OUT and state RUN and flush low.
REQ-021 Grant = first eligible index scanning ptr, ptr+1, ... mod NUM_REQ; at most one grant per cycle; combinational, zero-cycle latency to fpu_req_*.
REQ-022 fpu_req_valid = any grant; fpu_req_bits/tag from granted index; req_ready[i] = grant[i] and fpu_req_ready.
REQ-023 ptr updates to (granted index + 1) mod NUM_REQ only on a completed FPU request handshake; otherwise holds.
REQ-024 Grant shall be held stable (same index) while fpu_req_valid high and fpu_req_ready low, provided the requester keeps req_valid high.
REQ-025 Response routing: resp_valid[fpu_resp_tag] = fpu_resp_valid (others 0), resp_bits = fpu_resp_bits, fpu_resp_ready = resp_ready[fpu_resp_tag]; suppressed (all 0) in FLUSH state or while flush high.
REQ-026 cnt[i] +1 on request accept for i, -1 on response delivered to i; both same cycle -> unchanged.
REQ-027 Response to requester with cnt 0 shall be delivered and cnt shall saturate at 0.
REQ-028 Requester at cnt = MAX_OUT is skipped by arbitration; others proceed.
REQ-029 State machine RUN/FLUSH: RUN -> FLUSH when flush high; FLUSH -> FLUSH while flush high, else RUN.
REQ-030 On the edge sampling flush high, all cnt cleared to 0 (overrides simultaneous increments/decrements); ptr unchanged.
REQ-031 fpu_flush = 1 exactly while state is FLUSH (registered, no glitches).
REQ-032 busy = OR of (cnt[i] != 0), registered-state derived.

Reset
REQ-033 On reset: ptr = 0, all cnt = 0, state RUN; thus fpu_flush = 0, busy = 0, and outputs req_ready/resp_valid/fpu_req_valid are 0 when no inputs are valid.
REQ-034 Reset asserted mid-transaction shall discard all counts immediately; no handshake completes while reset is high.

Verification
REQ-035 NUM_REQ=4, all req_valid high, fpu_req_ready high 8 cycles -> tags 0,1,2,3,0,1,2,3; ptr returns to 0.
REQ-036 Requester 2 only, MAX_OUT=4, no responses -> 4 accepts, 5th held (req_ready[2]=0), busy=1; one response tag 2 -> next cycle accept resumes.
REQ-037 fpu_req_ready low 3 cycles with req 1 and 3 valid, ptr=1 -> tag 1 held 3 cycles, accepted on 4th, ptr=2, then tag 3.
REQ-038 fpu_resp_valid with tag 3 and resp_ready[3]=0 for 2 cycles -> resp_valid=4'b1000, fpu_resp_ready=0 held; cnt[3] decrements only on the ready cycle.
REQ-039 Accept and response for requester 0 same cycle at cnt=2 -> cnt stays 2; flush pulse 1 cycle -> next cycle fpu_flush=1, all cnt=0, busy=0, no grants; following cycle RUN.
REQ-040 Assert reset asynchronously mid-cycle with cnt={1,2,0,3} -> cnt all 0, busy=0, fpu_flush=0 before next clock edge.
